// File: rtl/dds_pkg.sv
// Shared encodings for the DDS access sequencer: accumulator bus modes,
// host command opcodes and sequencer FSM states.
package dds_pkg;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_HOLD = 2'b01;
  localparam logic [1:0] MODE_RD   = 2'b10;
  localparam logic [1:0] MODE_WR   = 2'b11;

  localparam logic [2:0] OP_WR_FREQ    = 3'd0;
  localparam logic [2:0] OP_WR_PHASE   = 3'd1;
  localparam logic [2:0] OP_RD_FREQ    = 3'd2;
  localparam logic [2:0] OP_RD_PHASE   = 3'd3;
  localparam logic [2:0] OP_SET_STEP   = 3'd4;
  localparam logic [2:0] OP_SET_STOP   = 3'd5;
  localparam logic [2:0] OP_SWEEP_GO   = 3'd6;
  localparam logic [2:0] OP_SWEEP_HALT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [1:0] idle_mode(input logic run);
    return run ? MODE_RUN : MODE_HOLD;
  endfunction

endpackage

// File: rtl/dds_sweep_engine.sv
// Linear frequency-sweep engine: owns the frequency shadow, step/stop/start/dwell,
// the dwell counter and a single merged pending tuning-word write.
module dds_sweep_engine
  import dds_pkg::*;
#(
  parameter int M  = 48,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          freq_wr,
  input  logic          set_step,
  input  logic          set_stop,
  input  logic          go,
  input  logic          halt,
  input  logic [M-1:0]  data,
  input  logic          take,
  output logic          pending,
  output logic          pending_nxt,
  output logic [M-1:0]  next_val,
  output logic          next_wrap,
  output logic          active
);

  localparam logic [DW-1:0] ONE = DW'(1);

  logic [M-1:0]  shadow_r, step_r, stop_r, start_r, pend_val_r;
  logic [DW-1:0] dwell_r, cnt_r;
  logic          active_r, pend_r, pend_wrap_r;
  logic          expire_s, wrap_s;
  logic [M-1:0]  base_s, next_s;
  logic [M:0]    sum_s;
  logic [DW-1:0] dwell_in_s;

  // Dwell expiry and next tuning word; a write taken this cycle is the base for the next step.
  always_comb begin
    expire_s    = active_r && (cnt_r == (dwell_r - ONE)) && !go && !halt;
    base_s      = take ? pend_val_r : shadow_r;
    sum_s       = {1'b0, base_s} + {1'b0, step_r};
    wrap_s      = sum_s[M] || (sum_s[M-1:0] > stop_r);
    next_s      = wrap_s ? start_r : sum_s[M-1:0];
    dwell_in_s  = (data[DW-1:0] == {DW{1'b0}}) ? ONE : data[DW-1:0];
    pending_nxt = !halt && (expire_s || (pend_r && !take));
  end

  // Sweep configuration, counter and pending-write registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r    <= '0;
      step_r      <= '0;
      stop_r      <= '0;
      start_r     <= '0;
      pend_val_r  <= '0;
      dwell_r     <= '0;
      cnt_r       <= '0;
      active_r    <= 1'b0;
      pend_r      <= 1'b0;
      pend_wrap_r <= 1'b0;
    end else begin
      if (take)
        shadow_r <= pend_val_r;
      else if (freq_wr)
        shadow_r <= data;
      if (set_step)
        step_r <= data;
      if (set_stop)
        stop_r <= data;
      if (go) begin
        start_r  <= shadow_r;
        dwell_r  <= dwell_in_s;
        cnt_r    <= '0;
        active_r <= 1'b1;
      end else if (halt) begin
        active_r <= 1'b0;
      end else if (active_r) begin
        cnt_r <= expire_s ? {DW{1'b0}} : cnt_r + ONE;
      end
      // A later expiry overwrites an untaken one, so only the latest value is written.
      if (halt) begin
        pend_r <= 1'b0;
      end else if (expire_s) begin
        pend_r      <= 1'b1;
        pend_val_r  <= next_s;
        pend_wrap_r <= wrap_s;
      end else if (take) begin
        pend_r <= 1'b0;
      end
    end
  end

  assign pending   = pend_r;
  assign next_val  = pend_val_r;
  assign next_wrap = pend_wrap_r;
  assign active    = active_r;

endmodule

// File: rtl/dds_access_sequencer.sv
// Sole bus master of a phase_accumulator: turns host commands and sweep updates
// into single-cycle registered mode/fph/word bus accesses.
module dds_access_sequencer
  import dds_pkg::*;
#(
  parameter int M  = 48,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [M-1:0]  cmd_data,
  output logic          rsp_valid,
  output logic [M-1:0]  rsp_data,
  output logic [1:0]    mode,
  output logic          fph,
  inout  wire  [M-1:0]  word,
  output logic          sweep_active,
  output logic          sweep_wrap
);

  state_t        state_r, state_nxt;
  logic [1:0]    mode_r, mode_nxt;
  logic          fph_r, fph_nxt, drive_r, drive_nxt, ready_r, ready_nxt;
  logic          wrap_r, wrap_nxt, rsp_valid_r;
  logic [M-1:0]  wdata_r, wdata_nxt, rsp_data_r;
  logic          accept_s, take_s, wr_cmd_s, rd_cmd_s;
  logic          pend_s, pend_nxt_s, sw_wrap_s;
  logic [M-1:0]  sw_next_s;

  assign accept_s = cmd_valid && ready_r;
  assign take_s   = (state_r == ST_IDLE) && pend_s;
  assign wr_cmd_s = accept_s && ((cmd_op == OP_WR_FREQ) || (cmd_op == OP_WR_PHASE));
  assign rd_cmd_s = accept_s && ((cmd_op == OP_RD_FREQ) || (cmd_op == OP_RD_PHASE));

  dds_sweep_engine #(.M(M), .DW(DW)) u_sweep (
    .clk         (clk),
    .reset       (reset),
    .freq_wr     (accept_s && (cmd_op == OP_WR_FREQ)),
    .set_step    (accept_s && (cmd_op == OP_SET_STEP)),
    .set_stop    (accept_s && (cmd_op == OP_SET_STOP)),
    .go          (accept_s && (cmd_op == OP_SWEEP_GO)),
    .halt        (accept_s && (cmd_op == OP_SWEEP_HALT)),
    .data        (cmd_data),
    .take        (take_s),
    .pending     (pend_s),
    .pending_nxt (pend_nxt_s),
    .next_val    (sw_next_s),
    .next_wrap   (sw_wrap_s),
    .active      (sweep_active)
  );

  // Next state and next registered bus outputs; a pending sweep write beats host commands.
  always_comb begin
    state_nxt = ST_IDLE;
    mode_nxt  = idle_mode(run);
    fph_nxt   = 1'b0;
    drive_nxt = 1'b0;
    wdata_nxt = wdata_r;
    wrap_nxt  = 1'b0;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        if (take_s) begin
          state_nxt = ST_WRITE;
          mode_nxt  = MODE_WR;
          fph_nxt   = 1'b1;
          drive_nxt = 1'b1;
          wdata_nxt = sw_next_s;
          wrap_nxt  = sw_wrap_s;
        end else if (wr_cmd_s) begin
          state_nxt = ST_WRITE;
          mode_nxt  = MODE_WR;
          fph_nxt   = (cmd_op == OP_WR_FREQ);
          drive_nxt = 1'b1;
          wdata_nxt = cmd_data;
        end else if (rd_cmd_s) begin
          state_nxt = ST_READ;
          mode_nxt  = MODE_RD;
          fph_nxt   = (cmd_op == OP_RD_FREQ);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_READ:  state_nxt = ST_RESP;
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    ready_nxt = (state_nxt == ST_RESP) || ((state_nxt == ST_IDLE) && !pend_nxt_s);
  end

  // State and bus output registers; the read response is captured at the edge ending READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_HOLD;
      fph_r       <= 1'b0;
      drive_r     <= 1'b0;
      ready_r     <= 1'b0;
      wrap_r      <= 1'b0;
      wdata_r     <= '0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
    end else begin
      state_r     <= state_nxt;
      mode_r      <= mode_nxt;
      fph_r       <= fph_nxt;
      drive_r     <= drive_nxt;
      ready_r     <= ready_nxt;
      wrap_r      <= wrap_nxt;
      wdata_r     <= wdata_nxt;
      rsp_valid_r <= (state_r == ST_READ);
      if (state_r == ST_READ)
        rsp_data_r <= word;
    end
  end

  assign word       = drive_r ? wdata_r : {M{1'bz}};
  assign mode       = mode_r;
  assign fph        = fph_r;
  assign cmd_ready  = ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign sweep_wrap = wrap_r;

endmodule
